branch_predictor: RTL and testbench

Tagged branch-history predictor for the 3-stage RISC-V core. Decode issues a combinational lookup and receives `br_pred_taken`, which selects the predicted PC. Execute sends back the resolved outcome one or more cycles later, and the table and the performance counters are updated on the clock edge. The block is the counterpart of decode's `pc_sel`/`is_br` logic: decode reads predictions from it and execute writes them.

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_predictor_bht_array.sv | 52 +++++
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the tagged branch predictor: counter encodings,
// default geometry and the PC index/tag slicing helpers.
package branch_predictor_pkg;

  localparam int LINES_DEFAULT = 64;
  localparam int TAG_W_DEFAULT = 8;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Index is pc[idx_w+1:2]; returned zero-extended, callers narrow it.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Partial tag is pc[idx_w+2+tag_w-1 : idx_w+2].
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w,
                                         input int tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_bht_array.sv
// Branch history table storage: per-line valid/tag/2-bit counter, asynchronous
// reads for the decode lookup and the execute update, one synchronous write.
module bht_array
  import branch_predictor_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [1:0]       up_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [1:0]       wr_ctr
);

  logic             valid_q [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [1:0]       ctr_q   [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_ctr   = ctr_q[rd_idx];
  assign up_valid = valid_q[up_idx];
  assign up_tag   = tag_q[up_idx];
  assign up_ctr   = ctr_q[up_idx];

  // Reset wins over a coincident write; every write leaves the line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged 2-bit branch predictor: combinational lookup for decode, hit/allocate
// update from execute, mispredict flag and resolved/mispredicted branch counts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_guess,
  input  logic        is_br_guess,
  output logic        br_pred_taken,
  input  logic [31:0] pc_check,
  input  logic        is_br_check,
  input  logic        pred_taken_check,
  input  logic        br_taken_check,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int IDX_W = $clog2(LINES);

  logic [IDX_W-1:0] guess_idx, check_idx;
  logic [TAG_W-1:0] guess_tag, check_tag;
  logic             rd_valid, up_valid;
  logic [TAG_W-1:0] rd_tag, up_tag;
  logic [1:0]       rd_ctr, up_ctr, new_ctr;
  logic             check_hit;

  assign guess_idx = IDX_W'(pc_index(pc_guess, IDX_W));
  assign guess_tag = TAG_W'(pc_tag(pc_guess, IDX_W, TAG_W));
  assign check_idx = IDX_W'(pc_index(pc_check, IDX_W));
  assign check_tag = TAG_W'(pc_tag(pc_check, IDX_W, TAG_W));

  bht_array #(.LINES(LINES), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (guess_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_ctr   (rd_ctr),
    .up_idx   (check_idx),
    .up_valid (up_valid),
    .up_tag   (up_tag),
    .up_ctr   (up_ctr),
    .we       (is_br_check),
    .wr_idx   (check_idx),
    .wr_tag   (check_tag),
    .wr_ctr   (new_ctr)
  );

  // Lookup reads the pre-update table, so a same-cycle update is not bypassed.
  assign br_pred_taken = is_br_guess & rd_valid & (rd_tag == guess_tag) & rd_ctr[1];

  assign check_hit  = up_valid & (up_tag == check_tag);
  assign mispredict = is_br_check & (pred_taken_check != br_taken_check);

  // is_br_check is a single-cycle strobe with no backpressure: every cycle it
  // is high applies exactly one update, so execute must drop it while stalled.
  always_comb begin
    new_ctr = br_taken_check ? CTR_WT : CTR_WNT;
    if (check_hit) begin
      if (br_taken_check) new_ctr = (up_ctr == CTR_ST) ? CTR_ST : up_ctr + 2'd1;
      else                new_ctr = (up_ctr == CTR_SNT) ? CTR_SNT : up_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (is_br_check) br_count      <= br_count + 32'd1;
      if (mispredict)  mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with an expected-value queue
// popped by an independent monitor on the falling edge.
module tb_branch_predictor;

  localparam int W = 66;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_guess = '0;
  logic        is_br_guess = 1'b0;
  logic        br_pred_taken;
  logic [31:0] pc_check = '0;
  logic        is_br_check = 1'b0;
  logic        pred_taken_check = 1'b0;
  logic        br_taken_check = 1'b0;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  logic         chk_req = 1'b0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .pc_guess         (pc_guess),
    .is_br_guess      (is_br_guess),
    .br_pred_taken    (br_pred_taken),
    .pc_check         (pc_check),
    .is_br_check      (is_br_check),
    .pred_taken_check (pred_taken_check),
    .br_taken_check   (br_taken_check),
    .mispredict       (mispredict),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  // One vector per cycle: drive just after the rising edge, monitor samples
  // combinational outputs and counters before the next rising edge.
  task automatic step(input string nm, input logic rst_v,
                      input logic [31:0] gpc, input logic gbr,
                      input logic [31:0] cpc, input logic cbr,
                      input logic cpred, input logic ctaken,
                      input logic e_pred, input logic e_mis,
                      input logic [31:0] e_bc, input logic [31:0] e_mc);
    @(posedge clk);
    #1;
    rst              = rst_v;
    pc_guess         = gpc;
    is_br_guess      = gbr;
    pc_check         = cpc;
    is_br_check      = cbr;
    pred_taken_check = cpred;
    br_taken_check   = ctaken;
    exp_q.push_back({e_pred, e_mis, e_bc, e_mc});
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    chk_req     = 1'b0;
    is_br_check = 1'b0;
    is_br_guess = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL underflow: output sampled with no expected entry");
      end else begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {br_pred_taken, mispredict, br_count, mispred_count};
        n_vec++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got pred=%b mis=%b br=%h mp=%h, want pred=%b mis=%b br=%h mp=%h",
                   nm, act_v[65], act_v[64], act_v[63:32], act_v[31:0],
                   exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    //    name            rst gpc           gbr cpc           cbr pr tk  pred mis br            mp
    step("cold_lookup",   0, 32'h1000, 1, 32'h0,    0, 0, 0,  0, 0, 32'd0,  32'd0);
    step("alloc_wt",      0, 32'h1000, 1, 32'h1000, 1, 0, 1,  0, 1, 32'd0,  32'd0);
    step("wt_to_st",      0, 32'h1000, 1, 32'h1000, 1, 1, 1,  1, 0, 32'd1,  32'd1);
    step("st_saturate",   0, 32'h1000, 1, 32'h1000, 1, 1, 1,  1, 0, 32'd2,  32'd1);
    step("st_lookup",     0, 32'h1000, 1, 32'h0,    0, 0, 0,  1, 0, 32'd3,  32'd1);
    step("st_to_wt",      0, 32'h1000, 1, 32'h1000, 1, 1, 0,  1, 1, 32'd3,  32'd1);
    step("wt_to_wnt",     0, 32'h1000, 1, 32'h1000, 1, 1, 0,  1, 1, 32'd4,  32'd2);
    step("wnt_lookup",    0, 32'h1000, 1, 32'h0,    0, 0, 0,  0, 0, 32'd5,  32'd3);
    step("wnt_to_wt",     0, 32'h1000, 1, 32'h1000, 1, 0, 1,  0, 1, 32'd5,  32'd3);
    step("conflict_ovw",  0, 32'h1000, 1, 32'h1100, 1, 0, 0,  1, 0, 32'd6,  32'd4);
    step("conflict_miss", 0, 32'h1000, 1, 32'h0,    0, 0, 0,  0, 0, 32'd7,  32'd4);
    step("new_tag_inc",   0, 32'h1100, 1, 32'h1100, 1, 0, 1,  0, 1, 32'd7,  32'd4);
    step("new_tag_wt",    0, 32'h1100, 1, 32'h0,    0, 0, 0,  1, 0, 32'd8,  32'd5);
    step("non_branch",    0, 32'h1100, 0, 32'h0,    0, 0, 0,  0, 0, 32'd8,  32'd5);
    step("back_to_wnt",   0, 32'h1000, 1, 32'h1100, 1, 1, 0,  0, 1, 32'd8,  32'd5);
    step("rbw_same_cyc",  0, 32'h2000, 1, 32'h2000, 1, 0, 1,  0, 1, 32'd9,  32'd6);
    step("rbw_next_cyc",  0, 32'h2000, 1, 32'h0,    0, 0, 0,  1, 0, 32'd10, 32'd7);
    step("diff_index",    0, 32'h2000, 1, 32'h1004, 1, 0, 0,  1, 0, 32'd10, 32'd7);
    step("idx1_alloc",    0, 32'h1004, 1, 32'h0,    0, 0, 0,  0, 0, 32'd11, 32'd7);
    step("strobe_low",    0, 32'h2000, 1, 32'h2000, 0, 1, 0,  1, 0, 32'd11, 32'd7);
    step("no_update",     0, 32'h2000, 1, 32'h0,    0, 0, 0,  1, 0, 32'd11, 32'd7);
    idle();
    force dut.br_count = 32'hFFFF_FFFF;
    #1;
    release dut.br_count;
    step("wrap_update",   0, 32'h2000, 1, 32'h2000, 1, 1, 1,  1, 0, 32'hFFFF_FFFF, 32'd7);
    step("wrap_zero",     0, 32'h2000, 1, 32'h0,    0, 0, 0,  1, 0, 32'd0,  32'd7);
    step("rst_with_upd",  1, 32'h2000, 0, 32'h3000, 1, 0, 1,  0, 1, 32'd0,  32'd7);
    step("rst_dropped",   0, 32'h3000, 1, 32'h0,    0, 0, 0,  0, 0, 32'd0,  32'd0);
    step("rst_cleared",   0, 32'h2000, 1, 32'h0,    0, 0, 0,  0, 0, 32'd0,  32'd0);
    step("post_rst_alloc",0, 32'h2000, 1, 32'h2000, 1, 0, 1,  0, 1, 32'd0,  32'd0);
    step("post_rst_pred", 0, 32'h2000, 1, 32'h0,    0, 0, 0,  1, 0, 32'd1,  32'd1);
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
